// File: rtl/pwm_sample_scheduler_if.sv
// Sample stream handshake between the upstream sample source and the scheduler.
interface pwm_sample_scheduler_if #(
  parameter int unsigned DUTY_WIDTH = 6
);
  logic                  valid;
  logic [DUTY_WIDTH-1:0] data;
  logic                  ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pwm_sample_scheduler.sv
// Buffers PWM duty samples and hands one to the generator per PWM period,
// with start/stop sequencing and underrun substitution/statistics.
module pwm_sample_scheduler #(
  parameter int unsigned AM_PWM_STEPS         = 64,
  parameter int unsigned AM_CLKS_IN_PWM_STEPS = 4,
  parameter int unsigned DUTY_WIDTH           = 6,
  parameter int unsigned IDLE_DUTY            = AM_PWM_STEPS / 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     clear_underrun,
  pwm_sample_scheduler_if.slave    sample,
  output logic                     pwm_enable,
  output logic [DUTY_WIDTH-1:0]    duty,
  output logic                     symbol,
  output logic                     busy,
  output logic                     underrun,
  output logic [15:0]              underrun_cnt
);

  localparam int unsigned CW = (AM_CLKS_IN_PWM_STEPS > 1) ? $clog2(AM_CLKS_IN_PWM_STEPS) : 1;
  localparam int unsigned SW = (AM_PWM_STEPS > 1) ? $clog2(AM_PWM_STEPS) : 1;
  localparam logic [CW-1:0] ClkLast  = CW'(AM_CLKS_IN_PWM_STEPS - 1);
  localparam logic [SW-1:0] StepLast = SW'(AM_PWM_STEPS - 1);
  localparam int unsigned   MaxDuty  = AM_PWM_STEPS - 1;
  localparam logic [DUTY_WIDTH-1:0] IdleDuty = DUTY_WIDTH'(IDLE_DUTY);
  localparam logic [DUTY_WIDTH-1:0] ClampDuty = DUTY_WIDTH'(MaxDuty);

  typedef enum logic [1:0] {StIdle, StPrime, StRun} state_e;

  state_e                state;
  logic [DUTY_WIDTH-1:0] buf_mem [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            count;
  logic [CW-1:0]         clk_cnt;
  logic [SW-1:0]         step_cnt;
  logic                  stop_pending;

  logic                  push;
  logic                  pop;
  logic                  boundary;
  logic                  ending;
  logic                  underrun_evt;
  logic [DUTY_WIDTH-1:0] push_data;

  assign sample.ready = (count < 2'd2);
  assign busy         = (state != StIdle);

  always_comb begin
    push         = sample.valid & sample.ready;
    push_data    = (32'(sample.data) > MaxDuty) ? ClampDuty : sample.data;
    boundary     = (state == StRun) && (clk_cnt == ClkLast) && (step_cnt == StepLast);
    // A stop arriving in the boundary cycle itself still ends this period.
    ending       = boundary && (stop_pending || stop);
    underrun_evt = boundary && !ending && (count == 2'd0);
    pop          = ((state == StPrime) && !stop && (count != 2'd0)) ||
                   (boundary && !ending && (count != 2'd0));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= StIdle;
      buf_mem[0]   <= '0;
      buf_mem[1]   <= '0;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      count        <= 2'd0;
      clk_cnt      <= '0;
      step_cnt     <= '0;
      stop_pending <= 1'b0;
      pwm_enable   <= 1'b0;
      duty         <= IdleDuty;
      symbol       <= 1'b0;
      underrun     <= 1'b0;
      underrun_cnt <= 16'd0;
    end else begin
      symbol <= 1'b0;

      if (push) begin
        buf_mem[wr_ptr] <= push_data;
        wr_ptr          <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      if (ending) begin
        count  <= 2'd0;
        wr_ptr <= 1'b0;
        rd_ptr <= 1'b0;
      end else begin
        count <= count + {1'b0, push} - {1'b0, pop};
      end

      unique case (state)
        StIdle: begin
          if (start && !stop) state <= StPrime;
        end
        StPrime: begin
          if (stop) begin
            state <= StIdle;
          end else if (count != 2'd0) begin
            state      <= StRun;
            duty       <= buf_mem[rd_ptr];
            pwm_enable <= 1'b1;
            symbol     <= 1'b1;
            clk_cnt    <= '0;
            step_cnt   <= '0;
          end
        end
        StRun: begin
          if (stop) stop_pending <= 1'b1;
          if (clk_cnt == ClkLast) begin
            clk_cnt  <= '0;
            step_cnt <= (step_cnt == StepLast) ? '0 : step_cnt + 1'b1;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
          if (ending) begin
            state        <= StIdle;
            pwm_enable   <= 1'b0;
            duty         <= IdleDuty;
            stop_pending <= 1'b0;
          end else if (boundary) begin
            symbol <= 1'b1;
            duty   <= (count != 2'd0) ? buf_mem[rd_ptr] : IdleDuty;
          end
        end
        default: state <= StIdle;
      endcase

      // A clear coinciding with a new underrun leaves exactly that one event recorded.
      if (clear_underrun) begin
        underrun     <= underrun_evt;
        underrun_cnt <= {15'd0, underrun_evt};
      end else if (underrun_evt) begin
        underrun <= 1'b1;
        if (underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 16'd1;
      end
    end
  end

endmodule
